// File: rtl/rca_pr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rca_pr_types
// Description : Shared types for the RCA partial-reconfiguration scheduler.
// Revision    : 1.0
// ============================================================================
package rca_pr_types;

    localparam int BITSTREAM_ID_W_DEFAULT = 6;

    typedef logic [BITSTREAM_ID_W_DEFAULT-1:0] bitstream_id_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        ISSUE    = 3'd2,
        BUSY     = 3'd3,
        COMPLETE = 3'd4
    } pr_sched_state_t;

endpackage : rca_pr_types
`default_nettype wire

// File: rtl/rca_pr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface   : rca_pr_scheduler_if
// Description : Requester, PR-loader and completion signals of the scheduler.
// Revision    : 1.0
// ============================================================================
interface rca_pr_scheduler_if #(
    parameter int NUM_REQ        = 4,
    parameter int BITSTREAM_ID_W = 6
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [BITSTREAM_ID_W-1:0] req_bitstream_id [NUM_REQ];
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rca_config_locked;
    logic                      pr_start;
    logic [BITSTREAM_ID_W-1:0] pr_bitstream_id;
    logic                      pr_done;
    logic                      pr_error;
    logic                      pr_abort;
    logic                      pr_requests_incomplete;
    logic                      done_valid;
    logic [IDX_W-1:0]          done_req_idx;
    logic                      done_error;

    // Environment side: requesters, RCA lock source and PR loader
    modport master (
        output req_valid, req_bitstream_id, rca_config_locked, pr_done, pr_error,
        input  req_ready, pr_start, pr_bitstream_id, pr_abort,
               pr_requests_incomplete, done_valid, done_req_idx, done_error
    );

    modport slave (
        input  req_valid, req_bitstream_id, rca_config_locked, pr_done, pr_error,
        output req_ready, pr_start, pr_bitstream_id, pr_abort,
               pr_requests_incomplete, done_valid, done_req_idx, done_error
    );

endinterface : rca_pr_scheduler_if
`default_nettype wire

// File: rtl/rca_pr_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; search starts at pointer_i.
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]     requests_i,
    input  wire logic [IDX_W-1:0] pointer_i,
    output logic      [N-1:0]     grant_o,
    output logic      [IDX_W-1:0] grant_idx_o,
    output logic                  any_o
);

    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand_idx    = '0;
        for (int i = 0; i < N; i++) begin
            cand_idx = IDX_W'((int'(pointer_i) + i) % N);
            if (!any_o && requests_i[cand_idx]) begin
                any_o             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                grant_idx_o       = cand_idx;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rca_pr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rca_pr_scheduler
// Description : Round-robin PR request scheduler; one PR job outstanding,
//               held off while the RCA configuration is locked.
//               Optional BUSY watchdog enabled by macro RCA_PR_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module rca_pr_scheduler
    import rca_pr_types::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int BITSTREAM_ID_W = 6,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input wire logic        clk,
    input wire logic        rst,
    rca_pr_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rca_pr_scheduler: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    pr_sched_state_t           state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [BITSTREAM_ID_W-1:0] id_q, id_d;
    logic                      err_q, err_d;

    logic [NUM_REQ-1:0]        grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_any;
    logic                      timeout_hit;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .requests_i  (bus.req_valid),
        .pointer_i   (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

`ifdef RCA_PR_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A coincident pr_done takes priority over the watchdog
    assign timeout_hit  = (state_q == BUSY) && !bus.pr_done
                          && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign bus.pr_abort = timeout_hit;
`else
    assign timeout_hit  = 1'b0;
    assign bus.pr_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        idx_d            = idx_q;
        id_d             = id_q;
        err_d            = err_q;
        bus.req_ready    = '0;
        bus.pr_start     = 1'b0;
        bus.done_valid   = 1'b0;
        bus.done_req_idx = '0;
        bus.done_error   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    bus.req_ready = grant;
                    idx_d         = grant_idx;
                    id_d          = bus.req_bitstream_id[grant_idx];
                    ptr_d         = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                       : grant_idx + 1'b1;
                    err_d         = 1'b0;
                    state_d       = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.rca_config_locked) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.pr_start = 1'b1;
                state_d      = BUSY;
            end
            BUSY: begin
                if (bus.pr_done) begin
                    err_d   = bus.pr_error;
                    state_d = COMPLETE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                bus.done_valid   = 1'b1;
                bus.done_req_idx = idx_q;
                bus.done_error   = err_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pr_bitstream_id        = id_q;
    // Combinational so the grid blocks in the same cycle a request appears
    assign bus.pr_requests_incomplete = (state_q != IDLE) || (|bus.req_valid);

endmodule : rca_pr_scheduler
`default_nettype wire

// File: tb/tb_rca_pr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_pr_scheduler
// Description : Directed self-checking bench for rca_pr_scheduler.
// Revision    : 1.0
// ============================================================================
module tb_rca_pr_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rca_pr_scheduler_if #(.NUM_REQ(4), .BITSTREAM_ID_W(6)) bus ();

    rca_pr_scheduler #(
        .NUM_REQ        (4),
        .BITSTREAM_ID_W (6),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [5:0] ids [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ids[0] = 6'd10; ids[1] = 6'd21; ids[2] = 6'd42; ids[3] = 6'd63;
        bus.req_valid         = '0;
        for (int i = 0; i < 4; i++) bus.req_bitstream_id[i] = '0;
        bus.rca_config_locked = 1'b0;
        bus.pr_done           = 1'b0;
        bus.pr_error          = 1'b0;
        rst = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_start",      bus.pr_start, 0);
        chk("rst_done_valid", bus.done_valid, 0);
        chk("rst_abort",      bus.pr_abort, 0);
        chk("rst_id",         bus.pr_bitstream_id, 0);
        chk("rst_ready",      bus.req_ready, 0);
        chk("rst_incomplete", bus.pr_requests_incomplete, 0);
        chk("rst_done_idx",   bus.done_req_idx, 0);
        chk("rst_done_err",   bus.done_error, 0);
        rst = 1'b1;

        // Single request, no lock (cycle 0 = grant)
        bus.req_bitstream_id[2] = 6'd5;
        bus.req_valid = 4'b0100;
        #1;
        chk("t1_ready", bus.req_ready, 4'b0100);
        chk("t1_incomplete", bus.pr_requests_incomplete, 1);
        step();                                   // cycle 1, DRAIN
        bus.req_valid = '0;
        bus.pr_done   = 1'b1;                     // stray pr_done, must be ignored
        #1;
        chk("t1_ready_clr", bus.req_ready, 0);
        chk("t1_start_early", bus.pr_start, 0);
        step();                                   // cycle 2, ISSUE
        bus.pr_done = 1'b0;
        chk("t1_start", bus.pr_start, 1);
        chk("t1_id", bus.pr_bitstream_id, 5);
        step();                                   // cycle 3, BUSY
        chk("t1_start_once", bus.pr_start, 0);
        chk("t1_id_busy", bus.pr_bitstream_id, 5);
        step();
        step();
        step();                                   // cycle 6
        bus.pr_done = 1'b1;
        #1;
        chk("t1_done_early", bus.done_valid, 0);
        step();                                   // cycle 7, COMPLETE
        bus.pr_done = 1'b0;
        chk("t1_done_valid", bus.done_valid, 1);
        chk("t1_done_idx", bus.done_req_idx, 2);
        chk("t1_done_err", bus.done_error, 0);
        step();                                   // IDLE
        chk("t1_done_pulse", bus.done_valid, 0);
        chk("t1_idle_incomplete", bus.pr_requests_incomplete, 0);

        // Lock hold-off, then error completion with lock raised during ISSUE/BUSY
        bus.req_bitstream_id[1] = 6'd9;
        bus.req_valid = 4'b0010;
        bus.rca_config_locked = 1'b1;
        #1;
        chk("t2_ready", bus.req_ready, 4'b0010);
        step();
        bus.req_valid = '0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            chk("t2_hold_start", bus.pr_start, 0);
            chk("t2_hold_incomplete", bus.pr_requests_incomplete, 1);
            step();
        end
        bus.rca_config_locked = 1'b0;
        #1;
        chk("t2_unlock_start", bus.pr_start, 0);
        step();
        chk("t2_start", bus.pr_start, 1);
        chk("t2_id", bus.pr_bitstream_id, 9);
        bus.rca_config_locked = 1'b1;
        step();                                   // BUSY
        bus.pr_done  = 1'b1;
        bus.pr_error = 1'b1;
        #1;
        chk("t2_busy_start", bus.pr_start, 0);
        step();                                   // COMPLETE
        bus.pr_done  = 1'b0;
        bus.pr_error = 1'b0;
        bus.rca_config_locked = 1'b0;
        chk("t2_done_valid", bus.done_valid, 1);
        chk("t2_done_idx", bus.done_req_idx, 1);
        chk("t2_done_err", bus.done_error, 1);
        step();
        chk("t2_idle_done", bus.done_valid, 0);
        chk("t2_idle_err", bus.done_error, 0);

        // Reset mid-BUSY with other requests held; pointer must restart at 0
        bus.req_bitstream_id[2] = 6'd42;
        bus.req_valid = 4'b0100;
        #1;
        chk("t3_ready", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = '0;
        step();
        step();                                   // BUSY
        chk("t3_busy_incomplete", bus.pr_requests_incomplete, 1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) bus.req_bitstream_id[i] = ids[i];
        bus.req_valid = 4'b1111;
        step();
        rst = 1'b1;
        #1;
        chk("t3_rst_id", bus.pr_bitstream_id, 0);
        chk("t3_rst_done", bus.done_valid, 0);
        chk("t3_rst_start", bus.pr_start, 0);
        chk("t3_rst_err", bus.done_error, 0);

        // Fairness: all requesters held valid, grant order 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            chk("t4_ready", bus.req_ready, 32'd1 << (k % 4));
            step();                               // DRAIN
            chk("t4_ready_drain", bus.req_ready, 0);
            step();                               // ISSUE
            chk("t4_start", bus.pr_start, 1);
            chk("t4_id", bus.pr_bitstream_id, ids[k % 4]);
            step();                               // BUSY
            bus.pr_done = 1'b1;
            step();                               // COMPLETE
            bus.pr_done = 1'b0;
            if (k == 4) bus.req_valid = '0;
            chk("t4_done_valid", bus.done_valid, 1);
            chk("t4_done_idx", bus.done_req_idx, k % 4);
            step();
        end
        chk("t4_idle_incomplete", bus.pr_requests_incomplete, 0);

        // Watchdog
        bus.req_valid = 4'b0001;
        #1;
        chk("t5_ready", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = '0;
        step();
        step();                                   // first BUSY cycle
`ifdef RCA_PR_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            chk("t5_abort_early", bus.pr_abort, 0);
            step();
        end
        chk("t5_abort", bus.pr_abort, 1);
        step();
        chk("t5_abort_pulse", bus.pr_abort, 0);
        chk("t5_done_valid", bus.done_valid, 1);
        chk("t5_done_err", bus.done_error, 1);
        chk("t5_done_idx", bus.done_req_idx, 0);
        step();

        // pr_done coinciding with expiry wins
        bus.req_valid = 4'b1000;
        #1;
        chk("t6_ready", bus.req_ready, 4'b1000);
        step();
        bus.req_valid = '0;
        step();
        step();
        for (int i = 0; i < 7; i++) step();
        bus.pr_done = 1'b1;
        #1;
        chk("t6_no_abort", bus.pr_abort, 0);
        step();
        bus.pr_done = 1'b0;
        chk("t6_done_valid", bus.done_valid, 1);
        chk("t6_done_err", bus.done_error, 0);
        chk("t6_done_idx", bus.done_req_idx, 3);
        step();
`else
        for (int i = 0; i < 20; i++) begin
            chk("t5_no_abort", bus.pr_abort, 0);
            chk("t5_no_done", bus.done_valid, 0);
            step();
        end
        bus.pr_done = 1'b1;
        step();
        bus.pr_done = 1'b0;
        chk("t5_done_valid", bus.done_valid, 1);
        chk("t5_done_err", bus.done_error, 0);
        chk("t5_done_idx", bus.done_req_idx, 0);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rca_pr_scheduler
`default_nettype wire
